mem_stage: RTL and testbench

- Pipeline MEM stage of the 64-bit RISC-V core.
- Consumes EX results on the EX→MEM interface and drives the data-memory request/grant/response bus.
- Aligns and extends load data, then registers results toward WB.
- Generates mem_ready back to EX: EX advances its output register only while mem_ready is high.

---
 rtl/mem_stage_if.sv | 57 +++++
 rtl/mem_stage.sv | 184 ++++++++++++++++++
 tb/tb_mem_stage.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_if.sv
// EX->MEM, data-memory and write-back signal bundle for mem_stage.
// master: the MEM stage view. slave: the surrounding pipeline/memory view.
// MEM_MISALIGN_TRAP_EN adds the o_mem_misaligned flag.
interface mem_stage_if #(
    parameter int unsigned XLEN      = 64,
    parameter int unsigned REGADDR_W = 5
);
    logic                 i_ex_valid;
    logic                 i_ex_is_load;
    logic                 i_ex_is_store;
    logic [2:0]           i_ex_funct3;
    logic [XLEN-1:0]      i_ex_addr;
    logic [XLEN-1:0]      i_ex_result;
    logic [XLEN-1:0]      i_ex_store_data;
    logic [REGADDR_W-1:0] i_ex_rd;
    logic                 i_ex_rd_we;
    logic                 o_mem_ready;

    logic                 o_dmem_req;
    logic                 o_dmem_we;
    logic [XLEN-1:0]      o_dmem_addr;
    logic [XLEN-1:0]      o_dmem_wdata;
    logic [XLEN/8-1:0]    o_dmem_be;
    logic                 i_dmem_gnt;
    logic                 i_dmem_rvalid;
    logic [XLEN-1:0]      i_dmem_rdata;

    logic                 o_wb_valid;
    logic [REGADDR_W-1:0] o_wb_rd;
    logic                 o_wb_we;
    logic [XLEN-1:0]      o_wb_data;
`ifdef MEM_MISALIGN_TRAP_EN
    logic                 o_mem_misaligned;
`endif

    modport master (
        input  i_ex_valid, i_ex_is_load, i_ex_is_store, i_ex_funct3, i_ex_addr,
               i_ex_result, i_ex_store_data, i_ex_rd, i_ex_rd_we,
               i_dmem_gnt, i_dmem_rvalid, i_dmem_rdata,
        output o_mem_ready, o_dmem_req, o_dmem_we, o_dmem_addr, o_dmem_wdata,
               o_dmem_be, o_wb_valid, o_wb_rd, o_wb_we, o_wb_data
`ifdef MEM_MISALIGN_TRAP_EN
        , output o_mem_misaligned
`endif
    );

    modport slave (
        output i_ex_valid, i_ex_is_load, i_ex_is_store, i_ex_funct3, i_ex_addr,
               i_ex_result, i_ex_store_data, i_ex_rd, i_ex_rd_we,
               i_dmem_gnt, i_dmem_rvalid, i_dmem_rdata,
        input  o_mem_ready, o_dmem_req, o_dmem_we, o_dmem_addr, o_dmem_wdata,
               o_dmem_be, o_wb_valid, o_wb_rd, o_wb_we, o_wb_data
`ifdef MEM_MISALIGN_TRAP_EN
        , input o_mem_misaligned
`endif
    );
endinterface

// File: rtl/mem_stage.sv
// MEM stage of the RV64 pipeline: issues data-memory requests, aligns and
// extends load data, and registers results toward WB.
// MEM_MISALIGN_TRAP_EN: misaligned accesses are trapped (no request, flag
// pulse) instead of having their offset masked to natural alignment.
module mem_stage (
    input  logic        clk,
    input  logic        rst,
    mem_stage_if.master bus
);
    localparam int unsigned XLEN      = 64;
    localparam int unsigned REGADDR_W = 5;
    localparam int unsigned BE_W      = XLEN / 8;
    localparam int unsigned OFF_W     = 3;

    typedef enum logic [1:0] {IDLE, REQ, RSP} state_t;

    state_t               state_q, state_d;
    logic                 accept, acc_mem, acc_issue;
    logic [OFF_W-1:0]     align_mask, acc_off;
    logic [BE_W-1:0]      be_base;

    logic                 op_is_load;
    logic [2:0]           op_funct3;
    logic [OFF_W-1:0]     op_off;
    logic [REGADDR_W-1:0] op_rd;
    logic                 op_rd_we;
    logic                 dmem_we_q;
    logic [XLEN-1:0]      dmem_addr_q, dmem_wdata_q;
    logic [BE_W-1:0]      dmem_be_q;

    logic [XLEN-1:0]      shifted, load_ext;

    logic                 wb_valid_q, wb_we_q;
    logic [REGADDR_W-1:0] wb_rd_q;
    logic [XLEN-1:0]      wb_data_q;
`ifdef MEM_MISALIGN_TRAP_EN
    logic                 acc_misaligned;
    logic                 misaligned_q;
`endif

    // Decode the incoming access: size mask, aligned offset, issue decision.
    always_comb begin
        align_mask = 3'b111;
        be_base    = 8'h01;
        case (bus.i_ex_funct3[1:0])
            2'd0:    begin align_mask = 3'b111; be_base = 8'h01; end
            2'd1:    begin align_mask = 3'b110; be_base = 8'h03; end
            2'd2:    begin align_mask = 3'b100; be_base = 8'h0F; end
            default: begin align_mask = 3'b000; be_base = 8'hFF; end
        endcase
        acc_off = bus.i_ex_addr[2:0] & align_mask;
        accept  = (state_q == IDLE) && bus.i_ex_valid;
        acc_mem = bus.i_ex_is_load || bus.i_ex_is_store;
`ifdef MEM_MISALIGN_TRAP_EN
        acc_misaligned = |(bus.i_ex_addr[2:0] & ~align_mask);
        acc_issue      = accept && acc_mem && !acc_misaligned;
`else
        acc_issue      = accept && acc_mem;
`endif
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic; a load wins when both load and store are flagged.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (acc_issue)          state_d = REQ;
            REQ:     if (bus.i_dmem_gnt)     state_d = op_is_load ? RSP : IDLE;
            RSP:     if (bus.i_dmem_rvalid)  state_d = IDLE;
            default:                         state_d = IDLE;
        endcase
    end

    // Op register: latch the instruction and precompute the memory request.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_is_load   <= 1'b0;
            op_funct3    <= 3'd0;
            op_off       <= '0;
            op_rd        <= '0;
            op_rd_we     <= 1'b0;
            dmem_we_q    <= 1'b0;
            dmem_addr_q  <= '0;
            dmem_wdata_q <= '0;
            dmem_be_q    <= '0;
        end else if (accept) begin
            op_is_load   <= bus.i_ex_is_load;
            op_funct3    <= bus.i_ex_funct3;
            op_off       <= acc_off;
            op_rd        <= bus.i_ex_rd;
            op_rd_we     <= bus.i_ex_rd_we;
            dmem_we_q    <= bus.i_ex_is_store && !bus.i_ex_is_load;
            dmem_addr_q  <= {bus.i_ex_addr[XLEN-1:3], 3'b000};
            dmem_wdata_q <= bus.i_ex_store_data << {acc_off, 3'b000};
            dmem_be_q    <= BE_W'(be_base << acc_off);
        end
    end

    // Load alignment and sign/zero extension.
    always_comb begin
        shifted = bus.i_dmem_rdata >> {op_off, 3'b000};
        case (op_funct3)
            3'b000:  load_ext = {{56{shifted[7]}},  shifted[7:0]};
            3'b001:  load_ext = {{48{shifted[15]}}, shifted[15:0]};
            3'b010:  load_ext = {{32{shifted[31]}}, shifted[31:0]};
            3'b100:  load_ext = {56'd0, shifted[7:0]};
            3'b101:  load_ext = {48'd0, shifted[15:0]};
            3'b110:  load_ext = {32'd0, shifted[31:0]};
            default: load_ext = shifted;
        endcase
    end

    // Write-back register: one-cycle valid pulse, payload holds otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid_q   <= 1'b0;
            wb_we_q      <= 1'b0;
            wb_rd_q      <= '0;
            wb_data_q    <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
            misaligned_q <= 1'b0;
`endif
        end else begin
            wb_valid_q   <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
            misaligned_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (accept && !acc_mem) begin
                        wb_valid_q <= 1'b1;
                        wb_we_q    <= bus.i_ex_rd_we;
                        wb_rd_q    <= bus.i_ex_rd;
                        wb_data_q  <= bus.i_ex_result;
                    end
`ifdef MEM_MISALIGN_TRAP_EN
                    else if (accept && acc_misaligned) begin
                        wb_valid_q   <= 1'b1;
                        wb_we_q      <= 1'b0;
                        wb_rd_q      <= bus.i_ex_rd;
                        misaligned_q <= 1'b1;
                    end
`endif
                end
                REQ: begin
                    if (bus.i_dmem_gnt && !op_is_load) begin
                        wb_valid_q <= 1'b1;
                        wb_we_q    <= 1'b0;
                        wb_rd_q    <= op_rd;
                    end
                end
                RSP: begin
                    if (bus.i_dmem_rvalid) begin
                        wb_valid_q <= 1'b1;
                        wb_we_q    <= op_rd_we;
                        wb_rd_q    <= op_rd;
                        wb_data_q  <= load_ext;
                    end
                end
                default: ;
            endcase
        end
    end

    // Output drive.
    assign bus.o_mem_ready  = (state_q == IDLE);
    assign bus.o_dmem_req   = (state_q == REQ);
    assign bus.o_dmem_we    = dmem_we_q;
    assign bus.o_dmem_addr  = dmem_addr_q;
    assign bus.o_dmem_wdata = dmem_wdata_q;
    assign bus.o_dmem_be    = dmem_be_q;
    assign bus.o_wb_valid   = wb_valid_q;
    assign bus.o_wb_we      = wb_we_q;
    assign bus.o_wb_rd      = wb_rd_q;
    assign bus.o_wb_data    = wb_data_q;
`ifdef MEM_MISALIGN_TRAP_EN
    assign bus.o_mem_misaligned = misaligned_q;
`endif
endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with a write-back scoreboard.
// Honours MEM_MISALIGN_TRAP_EN the same way as the design.
module tb_mem_stage;
    logic clk = 1'b0;
    logic rst;

    mem_stage_if bus();

    mem_stage u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  rd;
        logic        we;
        logic        chk_payload;
        logic [63:0] data;
        logic        mis;
    } wb_exp_t;

    wb_exp_t sb[$];
    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_wb(input logic [4:0] rd, input logic we, input logic chk_payload,
                           input logic [63:0] data, input logic mis);
        wb_exp_t e;
        e = '{rd: rd, we: we, chk_payload: chk_payload, data: data, mis: mis};
        sb.push_back(e);
    endtask

    // One clock; an entry queued before this edge must pulse right after it.
    task automatic tick();
        wb_exp_t e;
        logic    exp_v;
        @(posedge clk);
        #1;
        exp_v = (sb.size() != 0);
        chk("wb_valid", 64'(bus.o_wb_valid), 64'(exp_v));
        if (exp_v) begin
            e = sb.pop_front();
            if (bus.o_wb_valid === 1'b1) begin
                chk("wb_we", 64'(bus.o_wb_we), 64'(e.we));
                if (e.chk_payload) begin
                    chk("wb_rd", 64'(bus.o_wb_rd), 64'(e.rd));
                    chk("wb_data", bus.o_wb_data, e.data);
                end
`ifdef MEM_MISALIGN_TRAP_EN
                chk("wb_misaligned", 64'(bus.o_mem_misaligned), 64'(e.mis));
`endif
            end
        end
`ifdef MEM_MISALIGN_TRAP_EN
        else chk("misaligned_idle", 64'(bus.o_mem_misaligned), 64'd0);
`endif
    endtask

    task automatic drive_op(input logic ld, input logic st, input logic [2:0] f3,
                            input logic [63:0] addr, input logic [63:0] res,
                            input logic [63:0] sdata, input logic [4:0] rd, input logic rd_we);
        bus.i_ex_valid      = 1'b1;
        bus.i_ex_is_load    = ld;
        bus.i_ex_is_store   = st;
        bus.i_ex_funct3     = f3;
        bus.i_ex_addr       = addr;
        bus.i_ex_result     = res;
        bus.i_ex_store_data = sdata;
        bus.i_ex_rd         = rd;
        bus.i_ex_rd_we      = rd_we;
    endtask

    task automatic clear_ex();
        bus.i_ex_valid    = 1'b0;
        bus.i_ex_is_load  = 1'b0;
        bus.i_ex_is_store = 1'b0;
    endtask

    // Full load transaction; optionally holds rvalid high during a REQ cycle.
    task automatic do_load(input string tag, input logic [2:0] f3, input logic [63:0] addr,
                           input logic [63:0] rdata, input logic [4:0] rd,
                           input logic [7:0] exp_be, input logic [63:0] exp_data,
                           input logic rv_in_req);
        drive_op(1'b1, 1'b0, f3, addr, 64'h0, 64'h0, rd, 1'b1);
        tick();
        clear_ex();
        chk({tag, "_req"},   64'(bus.o_dmem_req), 64'd1);
        chk({tag, "_we"},    64'(bus.o_dmem_we), 64'd0);
        chk({tag, "_addr"},  bus.o_dmem_addr, addr & ~64'h7);
        chk({tag, "_be"},    64'(bus.o_dmem_be), 64'(exp_be));
        chk({tag, "_ready"}, 64'(bus.o_mem_ready), 64'd0);
        if (rv_in_req) begin
            bus.i_dmem_rvalid = 1'b1;
            bus.i_dmem_rdata  = 64'hDEAD_BEEF_DEAD_BEEF;
            tick();
            bus.i_dmem_rvalid = 1'b0;
            chk({tag, "_req_hold"}, 64'(bus.o_dmem_req), 64'd1);
        end
        bus.i_dmem_gnt = 1'b1;
        tick();
        bus.i_dmem_gnt = 1'b0;
        chk({tag, "_rsp_req"}, 64'(bus.o_dmem_req), 64'd0);
        chk({tag, "_rsp_ready"}, 64'(bus.o_mem_ready), 64'd0);
        bus.i_dmem_rvalid = 1'b1;
        bus.i_dmem_rdata  = rdata;
        push_wb(rd, 1'b1, 1'b1, exp_data, 1'b0);
        tick();
        bus.i_dmem_rvalid = 1'b0;
        chk({tag, "_done_ready"}, 64'(bus.o_mem_ready), 64'd1);
    endtask

    initial begin
        int ready_low;

        rst = 1'b1;
        clear_ex();
        bus.i_ex_funct3     = 3'd0;
        bus.i_ex_addr       = '0;
        bus.i_ex_result     = '0;
        bus.i_ex_store_data = '0;
        bus.i_ex_rd         = '0;
        bus.i_ex_rd_we      = 1'b0;
        bus.i_dmem_gnt      = 1'b0;
        bus.i_dmem_rvalid   = 1'b0;
        bus.i_dmem_rdata    = '0;

        // Reset state.
        tick();
        tick();
        chk("rst_wb_data", bus.o_wb_data, 64'd0);
        chk("rst_wb_we", 64'(bus.o_wb_we), 64'd0);
        chk("rst_wb_rd", 64'(bus.o_wb_rd), 64'd0);
        chk("rst_req", 64'(bus.o_dmem_req), 64'd0);
        chk("rst_ready", 64'(bus.o_mem_ready), 64'd1);
        rst = 1'b0;
        tick();

        // Back-to-back ALU results, one-cycle latency, ready never drops.
        for (int i = 0; i < 3; i++) begin
            drive_op(1'b0, 1'b0, 3'd0, 64'h0, 64'(8'h11 * (i + 1)), 64'h0, 5'(i + 1), 1'b1);
            push_wb(5'(i + 1), 1'b1, 1'b1, 64'(8'h11 * (i + 1)), 1'b0);
            tick();
            chk("alu_ready", 64'(bus.o_mem_ready), 64'd1);
        end
        clear_ex();
        tick();

        // SB at 0x1005, grant in the third request cycle.
        drive_op(1'b0, 1'b1, 3'b000, 64'h1005, 64'h0, 64'hAB, 5'd0, 1'b0);
        ready_low = 0;
        tick();
        clear_ex();
        for (int c = 0; c < 3; c++) begin
            if (bus.o_mem_ready === 1'b0) ready_low++;
            chk("sb_req", 64'(bus.o_dmem_req), 64'd1);
            chk("sb_we", 64'(bus.o_dmem_we), 64'd1);
            chk("sb_addr", bus.o_dmem_addr, 64'h1000);
            chk("sb_be", 64'(bus.o_dmem_be), 64'h20);
            chk("sb_wdata", bus.o_dmem_wdata, 64'h0000_AB00_0000_0000);
            if (c == 2) begin
                bus.i_dmem_gnt = 1'b1;
                push_wb(5'd0, 1'b0, 1'b0, 64'h0, 1'b0);
            end
            tick();
        end
        bus.i_dmem_gnt = 1'b0;
        chk("sb_ready_low_cycles", 64'(ready_low), 64'd3);
        chk("sb_done_ready", 64'(bus.o_mem_ready), 64'd1);
        chk("sb_done_req", 64'(bus.o_dmem_req), 64'd0);

        // Loads: sign/zero extension and lane extraction.
        do_load("lb",  3'b000, 64'h2003, 64'h0000_0000_8000_0000, 5'd4, 8'h08,
                64'hFFFF_FFFF_FFFF_FF80, 1'b0);
        do_load("lbu", 3'b100, 64'h2003, 64'h0000_0000_8000_0000, 5'd5, 8'h08,
                64'h0000_0000_0000_0080, 1'b0);
        do_load("lw",  3'b010, 64'h3004, 64'h8765_4321_0000_0000, 5'd6, 8'hF0,
                64'hFFFF_FFFF_8765_4321, 1'b0);
        do_load("ld",  3'b011, 64'h3000, 64'h8765_4321_0000_0000, 5'd7, 8'hFF,
                64'h8765_4321_0000_0000, 1'b1);

        // Reset while waiting for the response; the late rvalid is dropped.
        drive_op(1'b1, 1'b0, 3'b011, 64'h5000, 64'h0, 64'h0, 5'd8, 1'b1);
        tick();
        clear_ex();
        bus.i_dmem_gnt = 1'b1;
        tick();
        bus.i_dmem_gnt = 1'b0;
        chk("rsp_rst_pre_ready", 64'(bus.o_mem_ready), 64'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rsp_rst_ready", 64'(bus.o_mem_ready), 64'd1);
        chk("rsp_rst_req", 64'(bus.o_dmem_req), 64'd0);
        bus.i_dmem_rvalid = 1'b1;
        bus.i_dmem_rdata  = 64'h1111_2222_3333_4444;
        tick();
        bus.i_dmem_rvalid = 1'b0;
        chk("late_rvalid_ready", 64'(bus.o_mem_ready), 64'd1);
        chk("late_rvalid_req", 64'(bus.o_dmem_req), 64'd0);

        // Misaligned LH at 0x4001.
`ifdef MEM_MISALIGN_TRAP_EN
        drive_op(1'b1, 1'b0, 3'b001, 64'h4001, 64'h0, 64'h0, 5'd9, 1'b1);
        push_wb(5'd9, 1'b0, 1'b0, 64'h0, 1'b1);
        tick();
        clear_ex();
        chk("mis_req", 64'(bus.o_dmem_req), 64'd0);
        chk("mis_ready", 64'(bus.o_mem_ready), 64'd1);
        tick();
        chk("mis_after_req", 64'(bus.o_dmem_req), 64'd0);
`else
        do_load("lh_mis", 3'b001, 64'h4001, 64'h1234_5678_9ABC_8001, 5'd9, 8'h03,
                64'hFFFF_FFFF_FFFF_8001, 1'b0);
`endif

        tick();
        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
